program_sequencer: RTL

- Program counter and next-address generator for the 8-bit processor. It sits directly upstream of the instruction decoder.
- It drives pm_addr into program memory; the memory output becomes the decoder's next_instr.
- It consumes the decoder's jmp, jmp_nz and ir_nibble, plus the ALU zero flag.
- It adds hold (stall) support and a single-level interrupt entry/return state machine.

---
 rtl/program_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/program_sequencer.sv
// Program counter / next-address generator with hold and one-level interrupt.
// Ports: clk, reset_n, jmp, jmp_nz, jmp_addr, dont_jmp, hold, irq, reti ->
//        pm_addr (comb), pc, int_active, from_PS; optional instr_count
//        when PSEQ_INSTR_COUNT_EN is defined.
module program_sequencer #(
    parameter int                   PM_ADDR_W    = 8,
    parameter logic [PM_ADDR_W-1:0] RESET_VECTOR = 8'h00,
    parameter logic [PM_ADDR_W-1:0] INT_VECTOR   = 8'hF0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 jmp,
    input  logic                 jmp_nz,
    input  logic [3:0]           jmp_addr,
    input  logic                 dont_jmp,
    input  logic                 hold,
    input  logic                 irq,
    input  logic                 reti,
    output logic [PM_ADDR_W-1:0] pm_addr,
    output logic [PM_ADDR_W-1:0] pc,
    output logic                 int_active,
    output logic [7:0]           from_PS
`ifdef PSEQ_INSTR_COUNT_EN
    ,
    output logic [15:0]          instr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVICE = 2'b01
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PM_ADDR_W-1:0] saved_pc;
    logic [PM_ADDR_W-1:0] saved_nxt;
    logic [PM_ADDR_W-1:0] pc_inc;
    logic [PM_ADDR_W-1:0] jump_tgt;
    logic [4:0]           dbg_low;

    assign pc_inc   = pc + PM_ADDR_W'(1);
    assign jump_tgt = PM_ADDR_W'({jmp_addr, 4'h0});

    // Next address in priority order; pm_addr tracks the reset vector
    // while reset is held so memory already fetches the first word.
    always_comb begin
        pm_addr   = pc_inc;
        state_nxt = state;
        saved_nxt = saved_pc;
        if (!reset_n) begin
            pm_addr = RESET_VECTOR;
        end else if (hold) begin
            pm_addr = pc;
        end else if (reti && state == SERVICE) begin
            pm_addr   = saved_pc;
            state_nxt = IDLE;
        end else if (jmp) begin
            pm_addr = jump_tgt;
        end else if (jmp_nz && !dont_jmp) begin
            pm_addr = jump_tgt;
        end else if (irq && state == IDLE) begin
            pm_addr   = INT_VECTOR;
            saved_nxt = pc_inc;
            state_nxt = SERVICE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_VECTOR;
            state    <= IDLE;
            saved_pc <= '0;
        end else begin
            pc       <= pm_addr;
            state    <= state_nxt;
            saved_pc <= saved_nxt;
        end
    end

    assign int_active = (state == SERVICE);

`ifdef PSEQ_INSTR_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_count <= '0;
        end else if (!hold) begin
            instr_count <= instr_count + 16'd1;
        end
    end

    assign dbg_low = instr_count[4:0];
`else
    assign dbg_low = 5'h0;
`endif

    assign from_PS = {int_active, state, dbg_low};

endmodule
